fifo_tx: RTL

Transmit-side character FIFO for the SpaceWire link (ECSS-E-ST-50-12C). The host writes N-Chars (8-bit data plus a 1-bit EOP/EEP flag) into it, and the TX encoder reads them out. Reads are gated by the transmit credit count: each FCT received from the remote end adds 8 credits, and each N-Char read consumes 1. The block flags credit overflow (more than 56 credits) as a link error.

---
 rtl/fifo_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fifo_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_tx
// Description : SpaceWire transmit N-Char FIFO with FCT credit gating.
//               Host writes N-Chars; the TX encoder reads them only while
//               transmit credits are available. Credit overflow is flagged
//               as a sticky link error.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_tx #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              got_fct_in,
    input  logic              clear_credit,
    output logic              f_full,
    output logic              f_empty,
    output logic              ready_tx,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic [AWIDTH:0]   counter,
    output logic [6:0]        credit_counter,
    output logic              credit_error
);

    localparam int               c_DEPTH_INT   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]  c_DEPTH       = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]  c_CNT_ONE     = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] c_PTR_ONE    = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       c_CREDIT_MAX  = 8'd56;
    localparam logic [7:0]       c_FCT_CREDITS = 8'd8;

    logic [DWIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;

    logic              w_wr_accept;
    logic              w_rd_accept;
    logic [AWIDTH:0]   w_count_next;
    logic [6:0]        w_credit_after_rd;
    logic [7:0]        w_credit_with_fct;

    // A write is dropped whenever the FIFO is full, regardless of a same-cycle read.
    assign w_wr_accept = wr_en && !f_full;
    assign ready_tx    = !f_empty && (credit_counter != 7'd0);
    assign w_rd_accept = rd_en && ready_tx;

    // A read needs at least one credit, so this subtraction cannot underflow.
    assign w_credit_after_rd = credit_counter - {6'd0, w_rd_accept};
    assign w_credit_with_fct = {1'b0, w_credit_after_rd} + c_FCT_CREDITS;

    // Next occupancy; simultaneous accepted read and write cancel out.
    always_comb begin
        w_count_next = counter;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = counter + c_CNT_ONE;
            2'b01:   w_count_next = counter - c_CNT_ONE;
            default: w_count_next = counter;
        endcase
    end

    // Storage array; left unreset so it can map onto RAM.
    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and full/empty flags derived from the next count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            counter  <= '0;
            f_empty  <= 1'b1;
            f_full   <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            counter <= w_count_next;
            f_empty <= (w_count_next == '0);
            f_full  <= (w_count_next == c_DEPTH);
        end
    end

    // Registered read port: data_out holds between reads, data_valid pulses once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= w_rd_accept;
            if (w_rd_accept) begin
                data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // Credit accounting: an FCT that would push credits past 56 is discarded
    // and latches the sticky error; clear_credit overrides everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit_counter <= 7'd0;
            credit_error   <= 1'b0;
        end else if (clear_credit) begin
            credit_counter <= 7'd0;
            credit_error   <= 1'b0;
        end else if (got_fct_in) begin
            if (w_credit_with_fct > c_CREDIT_MAX) begin
                credit_counter <= w_credit_after_rd;
                credit_error   <= 1'b1;
            end else begin
                credit_counter <= w_credit_with_fct[6:0];
            end
        end else begin
            credit_counter <= w_credit_after_rd;
        end
    end

endmodule
`default_nettype wire
